// File: rtl/redirect_pkg.sv
// Shared types and flush masks for the PC-redirect controller.
// Flush mask bit order: {mem_wb, ex_mem, id_ex, if_id}.
package redirect_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_EX,
        SRC_MEM,
        SRC_WB
    } src_t;

    localparam logic [3:0] FLUSH_NONE = 4'b0000;
    localparam logic [3:0] FLUSH_EX   = 4'b0011;
    localparam logic [3:0] FLUSH_MEM  = 4'b0111;
    localparam logic [3:0] FLUSH_WB   = 4'b1111;

endpackage

// File: rtl/redirect_arb.sv
// Fixed-priority redirect select: the oldest requesting stage (WB > MEM > EX) wins.
import redirect_pkg::*;

module redirect_arb #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_ex_valid,
    input  logic [ADDR_WIDTH-1:0] i_ex_pc,
    input  logic                  i_mem_valid,
    input  logic [ADDR_WIDTH-1:0] i_mem_pc,
    input  logic                  i_wb_valid,
    input  logic [ADDR_WIDTH-1:0] i_wb_pc,
    output src_t                  o_src,
    output logic [ADDR_WIDTH-1:0] o_target,
    output logic [3:0]            o_flush
);

    always_comb begin
        o_src    = SRC_NONE;
        o_target = '0;
        o_flush  = FLUSH_NONE;
        if (i_wb_valid) begin
            o_src    = SRC_WB;
            o_target = i_wb_pc;
            o_flush  = FLUSH_WB;
        end else if (i_mem_valid) begin
            o_src    = SRC_MEM;
            o_target = i_mem_pc;
            o_flush  = FLUSH_MEM;
        end else if (i_ex_valid) begin
            o_src    = SRC_EX;
            o_target = i_ex_pc;
            o_flush  = FLUSH_EX;
        end
    end

endmodule

// File: rtl/redirect_ctrl.sv
// PC-redirect controller: arbitrates EX/MEM/WB redirects, holds the target until IF
// accepts it, and discards fetch responses that were issued from the stale PC.
import redirect_pkg::*;

module redirect_ctrl #(
    parameter logic [31:0] PC_ADDR         = 32'h8000_0000,
    parameter int          ADDR_WIDTH      = 32,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_redir_valid,
    input  logic [ADDR_WIDTH-1:0] ex_redir_pc,
    input  logic                  mem_redir_valid,
    input  logic [ADDR_WIDTH-1:0] mem_redir_pc,
    input  logic                  wb_redir_valid,
    input  logic [ADDR_WIDTH-1:0] wb_redir_pc,
    input  logic                  if_fetch_issue,
    input  logic                  if_fetch_return,
    output logic                  pc_redir_valid,
    output logic [ADDR_WIDTH-1:0] pc_redir_pc,
    input  logic                  pc_redir_ready,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic                  flush_mem_wb,
    output logic                  discard_fetch,
    output logic                  busy
);

    localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);

    state_t                r_state, w_state_nxt;
    logic                  r_valid, w_valid_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [CW-1:0]         r_outst, w_outst_nxt;
    logic [CW-1:0]         r_discard, w_discard_nxt;
    logic [CW-1:0]         w_hold_discard;

    src_t                  w_src;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [3:0]            w_flush;
    logic                  w_discard_fire;

    redirect_arb #(.ADDR_WIDTH(ADDR_WIDTH)) u_arb (
        .i_ex_valid  (ex_redir_valid),
        .i_ex_pc     (ex_redir_pc),
        .i_mem_valid (mem_redir_valid),
        .i_mem_pc    (mem_redir_pc),
        .i_wb_valid  (wb_redir_valid),
        .i_wb_pc     (wb_redir_pc),
        .o_src       (w_src),
        .o_target    (w_target),
        .o_flush     (w_flush)
    );

    // Outstanding-fetch count saturates on protocol errors instead of wrapping.
    always_comb begin
        w_outst_nxt = r_outst;
        if (if_fetch_issue && !if_fetch_return && r_outst != MAX_CNT)
            w_outst_nxt = r_outst + CW'(1);
        else if (if_fetch_return && !if_fetch_issue && r_outst != '0)
            w_outst_nxt = r_outst - CW'(1);
    end

    assign w_discard_fire = (r_state == DRAIN) && (r_discard != '0) && if_fetch_return;
    assign w_hold_discard = (if_fetch_issue && r_discard != MAX_CNT) ? r_discard + CW'(1) : r_discard;

    always_comb begin
        w_state_nxt   = r_state;
        w_valid_nxt   = r_valid;
        w_pc_nxt      = r_pc;
        w_discard_nxt = r_discard;
        if (w_src != SRC_NONE) begin
            w_state_nxt   = HOLD;
            w_valid_nxt   = 1'b1;
            w_pc_nxt      = w_target;
            w_discard_nxt = w_outst_nxt;
        end else begin
            case (r_state)
                HOLD: begin
                    // Fetches issued while the redirect is pending come from the stale PC.
                    w_discard_nxt = w_hold_discard;
                    if (pc_redir_ready) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = (w_hold_discard != '0) ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (r_discard == '0) begin
                        w_state_nxt = IDLE;
                    end else if (w_discard_fire) begin
                        w_discard_nxt = r_discard - CW'(1);
                        if (r_discard == CW'(1))
                            w_state_nxt = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_pc      <= PC_ADDR[ADDR_WIDTH-1:0];
            r_outst   <= '0;
            r_discard <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= w_valid_nxt;
            r_pc      <= w_pc_nxt;
            r_outst   <= w_outst_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    assign pc_redir_valid = r_valid;
    assign pc_redir_pc    = r_pc;
    assign flush_if_id    = w_flush[0];
    assign flush_id_ex    = w_flush[1];
    assign flush_ex_mem   = w_flush[2];
    assign flush_mem_wb   = w_flush[3];
    assign discard_fetch  = w_discard_fire;
    assign busy           = (r_state != IDLE);

    a_issue_overflow: assert property (@(posedge clk) disable iff (reset)
        !(if_fetch_issue && !if_fetch_return && r_outst == MAX_CNT));
    a_return_underflow: assert property (@(posedge clk) disable iff (reset)
        !(if_fetch_return && !if_fetch_issue && r_outst == '0));

endmodule
